// File: rtl/dnn_pkg.sv
// ============================================================================
//  Module      : dnn_pkg
//  Description : Shared widths, state encoding and ReLU helper for dnn_seq_ctrl.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package dnn_pkg;

    localparam int X_W   = 5;
    localparam int HID_W = 12;
    localparam int OUT_W = 17;
    localparam int N_IN  = 4;
    localparam int N_HID = 4;
    localparam int N_OUT = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        L1   = 2'd1,
        L2   = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic logic [HID_W-1:0] relu(input logic [HID_W-1:0] s);
        return s[HID_W-1] ? '0 : s;
    endfunction

endpackage

`default_nettype wire

// File: rtl/dnn_mac.sv
// ============================================================================
//  Module      : dnn_mac
//  Description : Shared signed multiply-accumulate; sum_o is the value the
//                accumulator register takes at the coming edge.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module dnn_mac
    import dnn_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [HID_W-1:0] a_i,
    input  logic signed [X_W-1:0]   b_i,
    input  logic                    clr_i,
    input  logic                    en_i,
    output logic signed [OUT_W-1:0] sum_o
);

    logic signed [OUT_W-1:0] acc_q;
    logic signed [OUT_W-1:0] prod;

    assign prod  = OUT_W'(a_i) * OUT_W'(b_i);
    assign sum_o = (clr_i ? '0 : acc_q) + prod;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (en_i) begin
            acc_q <= sum_o;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dnn_seq_ctrl.sv
// ============================================================================
//  Module      : dnn_seq_ctrl
//  Description : Time-multiplexed 4-4-2 dense network sequencer around one MAC.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module dnn_seq_ctrl
    import dnn_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [N_IN*X_W-1:0]           x,
    input  logic [N_IN*N_HID*X_W-1:0]     w1,
    input  logic [N_HID*N_OUT*X_W-1:0]    w2,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [OUT_W-1:0]       out0,
    output logic signed [OUT_W-1:0]       out1,
    output logic                          busy
);

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic                    accept;

    logic signed [X_W-1:0]   x_unp  [N_IN];
    logic signed [X_W-1:0]   w1_unp [N_IN*N_HID];
    logic signed [X_W-1:0]   w2_unp [N_HID*N_OUT];
    logic signed [X_W-1:0]   x_q    [N_IN];
    logic signed [X_W-1:0]   w1_q   [N_IN*N_HID];
    logic signed [X_W-1:0]   w2_q   [N_HID*N_OUT];
    logic signed [HID_W-1:0] hidden_q [N_HID];
    logic signed [OUT_W-1:0] out0_q, out1_q;

    logic signed [HID_W-1:0] mac_a;
    logic signed [X_W-1:0]   mac_b;
    logic                    mac_clr, mac_en;
    logic signed [OUT_W-1:0] mac_sum;

    for (genvar g = 0; g < N_IN; g++) begin : g_x_unp
        assign x_unp[g] = x[X_W*g +: X_W];
    end
    for (genvar g = 0; g < N_IN*N_HID; g++) begin : g_w1_unp
        assign w1_unp[g] = w1[X_W*g +: X_W];
    end
    for (genvar g = 0; g < N_HID*N_OUT; g++) begin : g_w2_unp
        assign w2_unp[g] = w2[X_W*g +: X_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        accept    = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = L1;
                    cnt_d   = '0;
                end
            end
            L1: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) begin
                    state_d = L2;
                    cnt_d   = '0;
                end
            end
            L2: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd7) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Counter low bits are the inner index; the whole count is the flat weight index.
    always_comb begin
        mac_a   = '0;
        mac_b   = '0;
        mac_clr = 1'b0;
        mac_en  = 1'b0;
        case (state_q)
            L1: begin
                mac_a   = HID_W'(x_q[cnt_q[1:0]]);
                mac_b   = w1_q[cnt_q];
                mac_clr = (cnt_q[1:0] == 2'd0);
                mac_en  = 1'b1;
            end
            L2: begin
                mac_a   = hidden_q[cnt_q[1:0]];
                mac_b   = w2_q[cnt_q[2:0]];
                mac_clr = (cnt_q[1:0] == 2'd0);
                mac_en  = 1'b1;
            end
            default: ;
        endcase
    end

    dnn_mac u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .a_i   (mac_a),
        .b_i   (mac_b),
        .clr_i (mac_clr),
        .en_i  (mac_en),
        .sum_o (mac_sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_IN; k++)        x_q[k]      <= '0;
            for (int k = 0; k < N_IN*N_HID; k++)  w1_q[k]     <= '0;
            for (int k = 0; k < N_HID*N_OUT; k++) w2_q[k]     <= '0;
            for (int k = 0; k < N_HID; k++)       hidden_q[k] <= '0;
            out0_q <= '0;
            out1_q <= '0;
        end else begin
            if (accept) begin
                for (int k = 0; k < N_IN; k++)        x_q[k]  <= x_unp[k];
                for (int k = 0; k < N_IN*N_HID; k++)  w1_q[k] <= w1_unp[k];
                for (int k = 0; k < N_HID*N_OUT; k++) w2_q[k] <= w2_unp[k];
            end
            // Results are captured from the MAC sum on the edge that completes them.
            if (state_q == L1 && cnt_q[1:0] == 2'd3) begin
                hidden_q[cnt_q[3:2]] <= relu(mac_sum[HID_W-1:0]);
            end
            if (state_q == L2 && cnt_q == 4'd3) begin
                out0_q <= mac_sum;
            end
            if (state_q == L2 && cnt_q == 4'd7) begin
                out1_q <= mac_sum;
            end
        end
    end

    assign out0 = out0_q;
    assign out1 = out1_q;

endmodule

`default_nettype wire

// File: tb/tb_dnn_seq_ctrl.sv
// ============================================================================
//  Module      : tb_dnn_seq_ctrl
//  Description : Self-checking bench for dnn_seq_ctrl against an integer model.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_dnn_seq_ctrl;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [19:0]        x;
    logic [79:0]        w1;
    logic [39:0]        w2;
    logic               out_valid;
    logic               out_ready;
    logic signed [16:0] out0;
    logic signed [16:0] out1;
    logic               busy;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int last_acc = -1;

    dnn_seq_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .w1        (w1),
        .w2        (w2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out0      (out0),
        .out1      (out1),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [79:0] fill(input int v);
        logic [4:0] v5;
        v5 = v[4:0];
        return {16{v5}};
    endfunction

    // Network evaluated directly from its definition with integer arithmetic.
    function automatic void model(input logic [19:0] xv, input logic [79:0] w1v,
                                  input logic [39:0] w2v, output int o0, output int o1);
        int hid [4];
        int s;
        for (int h = 0; h < 4; h++) begin
            s = 0;
            for (int i = 0; i < 4; i++)
                s += int'($signed(xv[5*i +: 5])) * int'($signed(w1v[5*(4*h+i) +: 5]));
            hid[h] = (s < 0) ? 0 : s;
        end
        o0 = 0;
        o1 = 0;
        for (int h = 0; h < 4; h++) begin
            o0 += hid[h] * int'($signed(w2v[5*h +: 5]));
            o1 += hid[h] * int'($signed(w2v[5*(4+h) +: 5]));
        end
    endfunction

    // Entered and left at a falling edge.
    task automatic run_vec(input string tag, input logic [19:0] xv, input logic [79:0] w1v,
                           input logic [39:0] w2v, input int hold, input bit keep);
        int e0, n, exp0, exp1;
        logic [31:0] r;
        model(xv, w1v, w2v, exp0, exp1);
        x = xv; w1 = w1v; w2 = w2v; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) check({tag, "_accept_timeout"}, 0, 1);
        @(posedge clk); #1;
        e0 = cyc;
        if (!keep) in_valid = 1'b0;
        if (keep && last_acc >= 0) check({tag, "_period"}, e0 - last_acc, 26);
        last_acc = e0;
        @(negedge clk);
        n = 0;
        while (!out_valid && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) check({tag, "_done_timeout"}, 0, 1);
        check({tag, "_latency"}, cyc - e0, 24);
        check({tag, "_out0"}, out0, exp0);
        check({tag, "_out1"}, out1, exp1);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            r = $urandom;
            x = r[19:0];
            in_valid = r[20];
            @(negedge clk);
            check({tag, "_hold_valid"}, out_valid, 1);
            check({tag, "_hold_ready"}, in_ready, 0);
            check({tag, "_hold_out0"}, out0, exp0);
            check({tag, "_hold_out1"}, out1, exp1);
        end
        if (hold > 0) in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        if (!keep) out_ready = 1'b0;
        @(negedge clk);
        check({tag, "_post_valid"}, out_valid, 0);
        check({tag, "_post_ready"}, in_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [79:0] a, b, c;
        logic [95:0] r96;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        x = '0; w1 = '0; w2 = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_out0", out0, 0);
        check("rst_out1", out1, 0);

        a = fill(1); b = fill(1); c = fill(1);
        run_vec("basic", a[19:0], b, c[39:0], 0, 0);
        a = fill(1); b = fill(-1); c = fill(7);
        run_vec("relu", a[19:0], b, c[39:0], 0, 0);
        a = fill(-16); b = fill(-16); c = fill(-16);
        run_vec("ext_neg", a[19:0], b, c[39:0], 0, 0);
        c = fill(15);
        run_vec("ext_pos", a[19:0], b, c[39:0], 0, 0);
        a = fill(1); b = fill(1); c = fill(1);
        run_vec("backpr", a[19:0], b, c[39:0], 10, 0);

        // Abandon a computation mid layer 1.
        x = a[19:0]; w1 = b; w2 = c[39:0]; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("midrst_busy_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_out0", out0, 0);
        check("midrst_out1", out1, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", in_ready, 1);
        run_vec("after_rst", a[19:0], b, c[39:0], 0, 0);

        out_ready = 1'b1;
        last_acc = -1;
        for (int k = 0; k < 3; k++) begin
            r96 = {$urandom, $urandom, $urandom};
            a = r96[79:0];
            r96 = {$urandom, $urandom, $urandom};
            b = r96[79:0];
            run_vec($sformatf("tput%0d", k), a[19:0], b, r96[95:56], 0, 1);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        last_acc = -1;

        for (int k = 0; k < 6; k++) begin
            r96 = {$urandom, $urandom, $urandom};
            a = r96[79:0];
            r96 = {$urandom, $urandom, $urandom};
            b = r96[79:0];
            run_vec($sformatf("rand%0d", k), a[19:0], b, r96[95:56], int'($urandom_range(0, 3)), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule

`default_nettype wire
